// File: rtl/csc_uart_out.sv
// Serial output port for the Crazy Small CPU. Snoops the RAM write bus and
// builds a byte from two nibble writes: one to HI_ADDR and one to LO_ADDR.
// Completed bytes go into a small FIFO and are sent as 8N1 frames on txd.
module csc_uart_out #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [7:0]  HI_ADDR      = 8'hFE,
    parameter logic [7:0]  LO_ADDR      = 8'hFF,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RAMwrite,
    input  logic [7:0] address,
    input  logic [3:0] data,
    output logic       txd,
    output logic       busy,
    output logic       full,
    output logic       dropped
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    idx;
    logic [2:0]    idx_inc;
    logic [7:0]    shift;

    logic [3:0]    hinib;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr_nxt;
    logic [PW-1:0] rptr_nxt;
    logic          empty;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          drop;

    // FIFO status and push/pop decisions for this cycle.
    always_comb begin
        empty    = (wptr == rptr);
        push_req = RAMwrite && (address == LO_ADDR);
        pop      = (state == IDLE) && !empty;
        // A push into a full FIFO is still accepted when the head leaves this cycle.
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        wptr_nxt = push ? wptr + PW'(1) : wptr;
        rptr_nxt = pop ? rptr + PW'(1) : rptr;
        idx_inc  = idx + 3'd1;
        busy     = (state != IDLE) || !empty;
    end

    // Nibble capture, FIFO pointers, full and sticky overflow flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            hinib   <= 4'd0;
            wptr    <= '0;
            rptr    <= '0;
            full    <= 1'b0;
            dropped <= 1'b0;
        end else begin
            if (RAMwrite && (address == HI_ADDR)) begin
                hinib <= data;
            end
            wptr <= wptr_nxt;
            rptr <= rptr_nxt;
            full <= (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]) && (wptr_nxt[AW] != rptr_nxt[AW]);
            if (drop) begin
                dropped <= 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wptr[AW-1:0]] <= {hinib, data};
        end
    end

    // Transmit FSM: txd is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            txd   <= 1'b1;
            timer <= '0;
            idx   <= 3'd0;
            shift <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    txd   <= 1'b1;
                    timer <= '0;
                    if (!empty) begin
                        shift <= mem[rptr[AW-1:0]];
                        txd   <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (timer == TIMER_LAST) begin
                        timer <= '0;
                        idx   <= 3'd0;
                        txd   <= shift[0];
                        state <= DATA;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DATA: begin
                    if (timer == TIMER_LAST) begin
                        timer <= '0;
                        if (idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            idx <= idx_inc;
                            txd <= shift[idx_inc];
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                STOP: begin
                    txd <= 1'b1;
                    if (timer == TIMER_LAST) begin
                        timer <= '0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csc_uart_out.sv
// Bench for csc_uart_out: a line receiver decodes txd frames and compares
// each byte with a queue of bytes expected from the writes driven.
module tb_csc_uart_out;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       RAMwrite;
    logic [7:0] address;
    logic [3:0] data;
    logic       txd;
    logic       busy;
    logic       full;
    logic       dropped;

    csc_uart_out #(
        .CLKS_PER_BIT(CPB),
        .HI_ADDR     (8'hFE),
        .LO_ADDR     (8'hFF),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .RAMwrite(RAMwrite),
        .address (address),
        .data    (data),
        .txd     (txd),
        .busy    (busy),
        .full    (full),
        .dropped (dropped)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];
    int         frames = 0;
    bit         rx_active = 1'b0;
    bit         rx_abort = 1'b0;
    logic [3:0] hi_model = 4'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Line receiver: samples txd once per cycle, every sample of a bit must agree.
    initial begin
        logic s[FRAME];
        int   n;
        bit   shape_ok;
        bit   pending;
        logic [7:0] rx_byte;
        n = 0;
        forever begin
            @(posedge clk);
            #2;
            if (reset || rx_abort) begin
                rx_active = 1'b0;
                rx_abort  = 1'b0;
                n = 0;
            end else if (!rx_active) begin
                if (txd === 1'b0) begin
                    rx_active = 1'b1;
                    s[0] = txd;
                    n = 1;
                    start_q.push_back(cyc);
                end
            end else begin
                s[n] = txd;
                n++;
                if (n == FRAME) begin
                    rx_active = 1'b0;
                    frames++;
                    shape_ok = 1'b1;
                    for (int b = 0; b < 10; b++) begin
                        for (int k = 1; k < CPB; k++) begin
                            if (s[b*CPB+k] !== s[b*CPB]) shape_ok = 1'b0;
                        end
                    end
                    if (s[0] !== 1'b0 || s[9*CPB] !== 1'b1) shape_ok = 1'b0;
                    for (int b = 0; b < 8; b++) rx_byte[b] = s[(b+1)*CPB];
                    check("frame_shape", shape_ok, 1);
                    pending = (exp_q.size() != 0);
                    check("frame_expected", pending, 1);
                    if (pending) check("frame_byte", rx_byte, exp_q.pop_front());
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic raw(input logic we, input logic [7:0] a, input logic [3:0] d);
        RAMwrite = we;
        address  = a;
        data     = d;
        @(posedge clk);
        #1;
        RAMwrite = 1'b0;
        if (we && a == 8'hFE) hi_model = d;
    endtask

    task automatic lo(input logic [3:0] d, input bit kept);
        raw(1'b1, 8'hFF, d);
        if (kept) exp_q.push_back({hi_model, d});
    endtask

    task automatic drain(input string tag, input int maxc);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy || rx_active) && k < maxc) begin
            step(1);
            k++;
        end
        check({tag, "_drain_queue"}, exp_q.size(), 0);
        check({tag, "_drain_busy"}, busy, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int f0;
        int k;
        reset    = 1'b1;
        RAMwrite = 1'b0;
        address  = 8'd0;
        data     = 4'd0;
        step(2);
        reset = 1'b0;

        // Reset state and quiet idle line.
        check("reset_outputs", {txd, busy, full, dropped}, 4'b1000);
        for (int i = 0; i < 50; i++) begin
            step(1);
            check("idle_outputs", {txd, busy, full, dropped}, 4'b1000);
        end

        // Single byte 0x41.
        start_q.delete();
        raw(1'b1, 8'hFE, 4'h4);
        lo(4'h1, 1'b1);
        n = cyc;
        check("single_busy_after_push", busy, 1);
        check("single_txd_still_high", txd, 1);
        step(1);
        check("single_txd_fall", txd, 0);
        step(39);
        check("single_busy_in_stop", busy, 1);
        step(2);
        check("single_busy_fallen", busy, 0);
        drain("single", 200);
        check("single_start_count", start_q.size(), 1);
        if (start_q.size() >= 1) check("single_start_cycle", start_q[0], n + 1);

        // Ignored addresses and a disabled strobe.
        f0 = frames;
        raw(1'b1, 8'h00, 4'h3);
        check("ign_00_busy", busy, 0);
        raw(1'b1, 8'h7F, 4'h3);
        check("ign_7f_busy", busy, 0);
        raw(1'b1, 8'hFD, 4'h3);
        check("ign_fd_busy", busy, 0);
        raw(1'b0, 8'hFF, 4'h3);
        check("ign_nowrite_busy", busy, 0);
        step(60);
        check("ign_no_frame", frames, f0);

        // High nibble reuse and back-to-back spacing.
        start_q.delete();
        raw(1'b1, 8'hFE, 4'hA);
        lo(4'h5, 1'b1);
        lo(4'h6, 1'b1);
        drain("b2b", 300);
        check("b2b_start_count", start_q.size(), 2);
        if (start_q.size() == 2) check("b2b_spacing", start_q[1] - start_q[0], FRAME + 1);

        // Overflow while a frame is in progress.
        raw(1'b1, 8'hFE, 4'h9);
        lo(4'h9, 1'b1);
        step(3);
        raw(1'b1, 8'hFE, 4'h1);
        for (int i = 0; i < 6; i++) begin
            lo(4'(i), i < DEPTH);
            check("ovf_full", full, (i >= DEPTH - 1) ? 1 : 0);
            check("ovf_dropped", dropped, (i >= DEPTH) ? 1 : 0);
        end
        drain("ovf", 1000);
        check("ovf_dropped_sticky", dropped, 1);
        check("ovf_full_cleared", full, 0);

        // Reset during data bit 3 abandons the frame and the queued bytes.
        raw(1'b1, 8'hFE, 4'h3);
        lo(4'hC, 1'b1);
        lo(4'hD, 1'b1);
        lo(4'hE, 1'b1);
        k = 0;
        while (txd !== 1'b0 && k < 10) begin
            step(1);
            k++;
        end
        check("mid_frame_started", txd, 0);
        step(4 * CPB + 1);
        reset = 1'b1;
        step(1);
        check("mid_reset_txd", txd, 1);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_flags", {full, dropped}, 2'b00);
        reset    = 1'b0;
        rx_abort = 1'b1;
        exp_q.delete();
        hi_model = 4'd0;
        f0 = frames;
        step(100);
        check("mid_no_stale_frames", frames, f0);
        check("mid_idle_busy", busy, 0);
        raw(1'b1, 8'hFE, 4'h5);
        lo(4'hA, 1'b1);
        drain("post_reset", 200);
        check("post_reset_frame_count", frames, f0 + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
